fetch2_ibuf: RTL

//  Second fetch stage, directly downstream of the PC/fetch-request stage. Takes the PC

---
 rtl/fetch2_ibuf.sv | 111 +++++++++++
 1 files changed

// File: rtl/fetch2_ibuf.sv
// Second fetch stage: tracks the single in-flight ICache request and queues
// {pc, inst, adef} for Decode in a small FIFO, back-pressuring the PC stage.
module fetch2_ibuf #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    output logic        stall_out,
    input  logic        icache_data_ok,
    input  logic [31:0] icache_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst,
    output logic        inst_adef,
    input  logic        decode_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_inst [DEPTH];
    logic          mem_adef [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          outstanding;
    logic          cancel_pending;
    logic [31:0]   out_pc;

    logic          pop;
    logic          resp;
    logic          room;
    logic          accept;
    logic          acc_fetch;
    logic          acc_adef;
    logic [CW:0]   occupancy;
    logic [1:0]    n_push;
    logic [PW-1:0] adef_ptr;

    // The outstanding request already owns a slot, so a resp never needs extra room.
    always_comb begin
        pop       = inst_valid && decode_ready;
        resp      = icache_data_ok && outstanding && !cancel_pending;
        occupancy = {1'b0, count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, outstanding};
        room      = occupancy < (CW+1)'(DEPTH);
        accept    = pc_valid && !clear && !cancel_pending && room && (!outstanding || resp);
        acc_fetch = accept && (pc_in[1:0] == 2'b00);
        acc_adef  = accept && (pc_in[1:0] != 2'b00);
        n_push    = {1'b0, resp} + {1'b0, acc_adef};
        adef_ptr  = wr_ptr + PW'(resp);
    end

    assign stall_out  = pc_valid && !accept;
    assign inst_valid = (count != '0);
    assign inst_pc    = mem_pc[rd_ptr];
    assign inst       = mem_inst[rd_ptr];
    assign inst_adef  = mem_adef[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            outstanding    <= 1'b0;
            cancel_pending <= 1'b0;
            out_pc         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]   <= '0;
                mem_inst[i] <= '0;
                mem_adef[i] <= 1'b0;
            end
        end else if (clear) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            outstanding    <= 1'b0;
            // A data_ok landing in the clear cycle is simply dropped; otherwise swallow the next one.
            cancel_pending <= outstanding && !icache_data_ok;
        end else begin
            if (resp) begin
                mem_pc[wr_ptr]   <= out_pc;
                mem_inst[wr_ptr] <= icache_rdata;
                mem_adef[wr_ptr] <= 1'b0;
            end
            if (acc_adef) begin
                mem_pc[adef_ptr]   <= pc_in;
                mem_inst[adef_ptr] <= '0;
                mem_adef[adef_ptr] <= 1'b1;
            end
            wr_ptr <= wr_ptr + PW'(n_push);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(n_push) - CW'(pop);
            if (acc_fetch) begin
                outstanding <= 1'b1;
                out_pc      <= pc_in;
            end else if (resp) begin
                outstanding <= 1'b0;
            end
            if (cancel_pending && icache_data_ok) begin
                cancel_pending <= 1'b0;
            end
        end
    end

endmodule
